// File: rtl/pipeline_hazard_unit_pkg.sv
// pipeline_hazard_unit_pkg
//   Shared types for the pipeline hazard controller and its forwarding unit.
//   - hazard_state_e : controller FSM state (RUN / MEM_WAIT)
//   - fwd_sel_e      : EX operand source select
//   - pipe_ctrl_t    : bundle of stage enables, flushes and PC controls
//   - CTRL_*         : canned control words for each pipeline response
package pipeline_hazard_unit_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  // Everything advances, nothing is squashed.
  localparam pipe_ctrl_t CTRL_NORMAL = '{
    pc_write: 1'b1, pc_src: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b0,
    id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1, mem_wb_flush: 1'b0};

  // Held in reset: nothing advances, all control-carrying registers are zeroed.
  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_write: 1'b0, pc_src: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
    id_ex_write: 1'b0, id_ex_flush: 1'b1, ex_mem_write: 1'b0, mem_wb_flush: 1'b1};

  // Data memory busy: IF..MEM hold, WB receives a bubble.
  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, pc_src: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
    id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b0, mem_wb_flush: 1'b1};

  // Taken branch in EX: redirect PC and squash the two younger instructions.
  localparam pipe_ctrl_t CTRL_BRANCH = '{
    pc_write: 1'b1, pc_src: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
    id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_write: 1'b1, mem_wb_flush: 1'b0};

  // Load-use: hold PC and IF_ID, put a bubble into EX.
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{
    pc_write: 1'b0, pc_src: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
    id_ex_write: 1'b1, id_ex_flush: 1'b1, ex_mem_write: 1'b1, mem_wb_flush: 1'b0};

endpackage

// File: rtl/pipeline_hazard_unit_forward_unit.sv
// forward_unit
//   Purely combinational EX operand forwarding selects.
//   Ports:
//     ex_rs1, ex_rs2         : source registers of the instruction in EX
//     mem_rd, mem_reg_write  : destination / write flag of EX_MEM
//     wb_rd, wb_reg_write    : destination / write flag of MEM_WB
//     fwd_a, fwd_b           : operand source selects (fwd_sel_e)
//   EX_MEM is the younger producer, so it wins over MEM_WB; x0 never forwards.
module forward_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output fwd_sel_e              fwd_a,
  output fwd_sel_e              fwd_b
);

  logic mem_valid;
  logic wb_valid;

  assign mem_valid = mem_reg_write && (mem_rd != '0);
  assign wb_valid  = wb_reg_write && (wb_rd != '0);

  always_comb begin
    fwd_a = FWD_RF;
    if (mem_valid && (mem_rd == ex_rs1))     fwd_a = FWD_MEM;
    else if (wb_valid && (wb_rd == ex_rs1))  fwd_a = FWD_WB;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (mem_valid && (mem_rd == ex_rs2))     fwd_b = FWD_MEM;
    else if (wb_valid && (wb_rd == ex_rs2))  fwd_b = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Stall / flush / forward controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   Inputs : register indices and control bits of the instructions in ID, EX,
//            MEM and WB, branch resolution from EX, data-memory req/ready.
//   Outputs: PC write/source, stage-register enables and flushes, EX operand
//            forwarding selects, sticky mem_timeout, performance counters and
//            state_dbg (current FSM state, for observation only).
//   Priority: reset > memory freeze > taken branch > load-use > normal.
//   Handshake: mem_req is held by EX_MEM while its access is outstanding; the
//   access completes in the cycle mem_ready is high, and in that cycle the
//   pipeline advances so the result is captured into MEM_WB.
//   Optional: define HAZARD_PERF_CNT_EN to build stall_count / flush_count;
//   otherwise both are tied to zero and no counter flops exist.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_flush,
  output logic                  ex_mem_write,
  output logic                  mem_wb_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count,
  output hazard_state_e         state_dbg
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX_V = WAIT_W'(MEM_WAIT_MAX);

  hazard_state_e     state, state_next;
  pipe_ctrl_t        ctrl;
  logic              freeze;
  logic              load_use;
  logic [WAIT_W-1:0] wait_cnt, wait_inc;
  logic              timeout_q, timeout_hit;
  fwd_sel_e          fwd_a_e, fwd_b_e;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (mem_req && !mem_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ready)             state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  assign state_dbg = state;

  // The completing cycle (mem_ready=1) is not frozen: the data is valid now,
  // so the pipeline advances and MEM_WB captures the finished access.
  assign freeze = !mem_ready && ((state == MEM_WAIT) || mem_req);

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    ctrl = CTRL_NORMAL;
    if (rst)                  ctrl = CTRL_RESET;
    else if (freeze)          ctrl = CTRL_FREEZE;
    else if (ex_branch_taken) ctrl = CTRL_BRANCH;
    else if (load_use)        ctrl = CTRL_LOAD_USE;
  end

  assign pc_write     = ctrl.pc_write;
  assign pc_src       = ctrl.pc_src;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_write  = ctrl.id_ex_write;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign mem_wb_flush = ctrl.mem_wb_flush;

  // ---------------- wait counter / timeout ----------------
  assign wait_inc    = (wait_cnt == WAIT_MAX_V) ? wait_cnt : wait_cnt + WAIT_W'(1);
  // The flag shows in the very MEM_WAIT cycle that brings the count to the
  // limit, then stays set through the flop.
  assign timeout_hit = (state == MEM_WAIT) && (wait_inc == WAIT_MAX_V);
  assign mem_timeout = timeout_q | timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (timeout_hit) timeout_q <= 1'b1;
      if (state == MEM_WAIT && !mem_ready) wait_cnt <= wait_inc;
      else                                 wait_cnt <= '0;
    end
  end

  // ---------------- forwarding ----------------
  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_forward_unit (
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a_e),
    .fwd_b         (fwd_b_e)
  );

  assign fwd_a = rst ? FWD_RF : fwd_a_e;
  assign fwd_b = rst ? FWD_RF : fwd_b_e;

  // ---------------- performance counters ----------------
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl.pc_write && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (!freeze && ex_branch_taken && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit
//   Directed bench for pipeline_hazard_unit (MEM_WAIT_MAX=4 so the timeout is
//   reachable quickly). Inputs change just after the falling edge and outputs
//   are sampled 1ns later, well before the next rising edge.
module tb_pipeline_hazard_unit;
  import pipeline_hazard_unit_pkg::*;

  localparam int RW = 5;
  localparam int CW = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // control word order: pc_write pc_src if_id_write if_id_flush
  //                     id_ex_write id_ex_flush ex_mem_write mem_wb_flush
  localparam logic [7:0] E_NORMAL = 8'b1010_1010;
  localparam logic [7:0] E_RESET  = 8'b0001_0101;
  localparam logic [7:0] E_FREEZE = 8'b0000_0001;
  localparam logic [7:0] E_LOADU  = 8'b0000_1110;
  localparam logic [7:0] E_BRANCH = 8'b1111_1110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic mem_reg_write, mem_req, mem_ready, wb_reg_write;
  logic pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, mem_wb_flush, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_count, flush_count;
  hazard_state_e state_dbg;

  pipeline_hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
    .mem_wb_flush(mem_wb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, pc_write, pc_src, if_id_write, if_id_flush,
                id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush}, {24'd0, exp});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    wb_rd = '0; wb_reg_write = 1'b0;
  endtask

  // Next stimulus slot: after the falling edge, so one rising edge has passed.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    drive_idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    drive_idle();

    // reset state and forced outputs
    next_cycle();
    mem_reg_write = 1'b1; mem_rd = 5'd7; ex_rs1 = 5'd7;
    #1;
    check_ctrl("reset_ctrl", E_RESET);
    check("reset_fwd_a", {30'd0, fwd_a}, 32'h0);
    check("reset_state", {31'd0, state_dbg}, {31'd0, RUN});
    check("reset_stall_cnt", {16'd0, stall_count}, 32'h0);
    check("reset_timeout", {31'd0, mem_timeout}, 32'h0);
    next_cycle();
    rst = 1'b0;
    drive_idle();
    #1;
    check_ctrl("normal_idle", E_NORMAL);

    // load-use: one bubble, then normal once the bubble is in EX
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    check_ctrl("load_use", E_LOADU);
    next_cycle();
    ex_mem_read = 1'b0; ex_rd = '0;
    #1;
    check_ctrl("load_use_release", E_NORMAL);
    check("load_use_stall_cnt", {16'd0, stall_count}, PERF ? 32'd1 : 32'd0);
    // rs2 match but ID does not read rs2 -> no hazard
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b0; id_rs1 = 5'd1;
    #1;
    check_ctrl("load_use_unused_rs2", E_NORMAL);
    // load into x0 never interlocks
    ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1;
    check_ctrl("load_use_x0", E_NORMAL);

    // branch beats concurrent load-use
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    check_ctrl("branch_over_load_use", E_BRANCH);
    next_cycle();
    drive_idle();
    #1;
    check("branch_flush_cnt", {16'd0, flush_count}, PERF ? 32'd1 : 32'd0);
    check("branch_stall_cnt", {16'd0, stall_count}, 32'd0);

    // memory wait: 3 frozen cycles then release; branch during freeze ignored
    do_reset();
    exp_q.push_back(E_FREEZE); exp_q.push_back(E_FREEZE);
    exp_q.push_back(E_FREEZE); exp_q.push_back(E_NORMAL);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      drive_idle();
      mem_req = 1'b1;
      mem_ready = (i == 3);
      ex_branch_taken = (i == 1);
      if (i == 2) begin
        mem_reg_write = 1'b1; mem_rd = 5'd4; ex_rs1 = 5'd4;
      end
      #1;
      check_ctrl($sformatf("mem_wait_ctrl_%0d", i), exp_q.pop_front());
      if (i == 0) check("mem_wait_state0", {31'd0, state_dbg}, {31'd0, RUN});
      if (i == 1) check("mem_wait_state1", {31'd0, state_dbg}, {31'd0, MEM_WAIT});
      if (i == 2) check("mem_wait_fwd_a", {30'd0, fwd_a}, 32'h2);
    end
    next_cycle();
    drive_idle();
    #1;
    check("mem_wait_back_to_run", {31'd0, state_dbg}, {31'd0, RUN});
    check("mem_wait_stall_cnt", {16'd0, stall_count}, PERF ? 32'd3 : 32'd0);
    check("mem_wait_flush_cnt", {16'd0, flush_count}, 32'd0);
    check("mem_wait_no_timeout", {31'd0, mem_timeout}, 32'd0);

    // one-cycle access stays in RUN
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    check_ctrl("one_cycle_access", E_NORMAL);
    next_cycle();
    drive_idle();
    #1;
    check("one_cycle_state", {31'd0, state_dbg}, {31'd0, RUN});

    // timeout: RUN cycle + 5 MEM_WAIT cycles with mem_ready low
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      check($sformatf("timeout_%0d", i), {31'd0, mem_timeout}, (i >= 4) ? 32'd1 : 32'd0);
    end
    check("timeout_still_waiting", {31'd0, state_dbg}, {31'd0, MEM_WAIT});
    next_cycle();
    rst = 1'b1;
    #1;
    check_ctrl("timeout_rst_ctrl", E_RESET);
    next_cycle();
    rst = 1'b0; mem_req = 1'b0;
    #1;
    check("timeout_cleared", {31'd0, mem_timeout}, 32'd0);
    check("timeout_rst_state", {31'd0, state_dbg}, {31'd0, RUN});

    // forwarding priority and x0
    drive_idle();
    mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    #1;
    check("fwd_a_mem_wins", {30'd0, fwd_a}, 32'h2);
    mem_reg_write = 1'b0;
    #1;
    check("fwd_a_wb", {30'd0, fwd_a}, 32'h1);
    mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; mem_reg_write = 1'b1;
    #1;
    check("fwd_a_x0", {30'd0, fwd_a}, 32'h0);
    wb_rd = 5'd3; ex_rs2 = 5'd3; mem_rd = 5'd2;
    #1;
    check("fwd_b_wb", {30'd0, fwd_b}, 32'h1);
    mem_rd = 5'd3;
    #1;
    check("fwd_b_mem", {30'd0, fwd_b}, 32'h2);

    // reset in the middle of MEM_WAIT
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    next_cycle();
    #1;
    check("mid_wait_state", {31'd0, state_dbg}, {31'd0, MEM_WAIT});
    rst = 1'b1;
    mem_reg_write = 1'b1; mem_rd = 5'd6; ex_rs2 = 5'd6;
    #1;
    check_ctrl("mid_wait_rst_ctrl", E_RESET);
    check("mid_wait_rst_fwd_b", {30'd0, fwd_b}, 32'h0);
    next_cycle();
    #1;
    check("mid_wait_rst_state", {31'd0, state_dbg}, {31'd0, RUN});
    check("mid_wait_rst_stall_cnt", {16'd0, stall_count}, 32'd0);
    check_ctrl("mid_wait_rst_held", E_RESET);
    next_cycle();
    rst = 1'b0;
    drive_idle();
    #1;
    check_ctrl("mid_wait_after_rst", E_NORMAL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
